ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard on the PS/2 port, which the design already uses for keyboard reception.
- Drives PS2_CLK and PS2_DATA open-drain, through low-enable outputs that the top level maps onto tristate pads.
- Runs in the CPU clock domain.
- Reports device acknowledge or failure to the requester.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_sync_edge.sv | 30 +++
 rtl/ps2_host_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter FSM states, frame constants and parity helper.
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    REQ,
    WAIT_FIRST,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    FAIL
  } ps2_state_t;

  localparam int PS2_DATA_BITS = 8;
  localparam int PS2_ACK_EDGE  = 11;

  // PS/2 frames carry odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pin plus a falling-edge detector on the synced level.
module ps2_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Idle PS/2 lines are high, so all stages reset to 1 to avoid a spurious edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
    end else begin
      meta_reg <= pin;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign fall  = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clocked-out frame,
// device acknowledge check, with per-phase timeouts and a one-cycle done/ack_ok result.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ           = 50000000,
  parameter int INHIBIT_US            = 100,
  parameter int FIRST_EDGE_TIMEOUT_US = 15000,
  parameter int EDGE_TIMEOUT_US       = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       busy
);

  localparam int CYC_PER_US  = CLK_FREQ_HZ / 1000000;
  localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int FIRST_CYC   = CYC_PER_US * FIRST_EDGE_TIMEOUT_US;
  localparam int EDGE_CYC    = CYC_PER_US * EDGE_TIMEOUT_US;
  localparam int MAX_A       = (INHIBIT_CYC > FIRST_CYC) ? INHIBIT_CYC : FIRST_CYC;
  localparam int MAX_CYC     = (MAX_A > EDGE_CYC) ? MAX_A : EDGE_CYC;
  localparam int CNT_W       = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] FIRST_LOAD   = CNT_W'(FIRST_CYC - 1);
  localparam logic [CNT_W-1:0] EDGE_LOAD    = CNT_W'(EDGE_CYC - 1);
  // Edge count just before the stop-bit edge (fe 10).
  localparam logic [3:0]       STOP_PREV    = 4'(PS2_ACK_EDGE - 2);

  logic clk_level, clk_fall;
  logic data_level, data_fall;

  ps2_sync_edge u_clk_sync (
    .clock (clock),
    .reset (reset),
    .pin   (ps2_clk_i),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clock (clock),
    .reset (reset),
    .pin   (ps2_data_i),
    .level (data_level),
    .fall  (data_fall)
  );

  ps2_state_t               state_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic [3:0]               edge_reg;
  logic [PS2_DATA_BITS:0]   shift_reg;
  logic                     result_reg;
  logic                     clk_oe_reg;
  logic                     data_oe_reg;
  logic                     done_reg;
  logic                     ack_ok_reg;
  logic                     tx_ready_reg;
  logic                     busy_reg;

  logic watch;
  logic progress;

  // States where the device owns the clock and a stalled bus must time out.
  assign watch    = (state_reg == WAIT_FIRST) || (state_reg == SHIFT) ||
                    (state_reg == ACK) || (state_reg == WAIT_IDLE);
  assign progress = (state_reg == WAIT_IDLE) ? (clk_level & data_level) : clk_fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      edge_reg     <= '0;
      shift_reg    <= '0;
      result_reg   <= 1'b0;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
      done_reg     <= 1'b0;
      ack_ok_reg   <= 1'b0;
      tx_ready_reg <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (watch && !progress && cnt_reg == '0) begin
        clk_oe_reg  <= 1'b0;
        data_oe_reg <= 1'b0;
        done_reg    <= 1'b1;
        ack_ok_reg  <= 1'b0;
        state_reg   <= FAIL;
      end else begin
        case (state_reg)
          IDLE: begin
            if (tx_valid) begin
              shift_reg    <= {odd_parity(tx_data), tx_data};
              cnt_reg      <= INHIBIT_LOAD;
              clk_oe_reg   <= 1'b1;
              tx_ready_reg <= 1'b0;
              busy_reg     <= 1'b1;
              state_reg    <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (cnt_reg == '0) begin
              data_oe_reg <= 1'b1;
              state_reg   <= REQ;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          REQ: begin
            clk_oe_reg <= 1'b0;
            cnt_reg    <= FIRST_LOAD;
            state_reg  <= WAIT_FIRST;
          end
          WAIT_FIRST: begin
            if (clk_fall) begin
              data_oe_reg <= ~shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              edge_reg    <= 4'd1;
              cnt_reg     <= EDGE_LOAD;
              state_reg   <= SHIFT;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          SHIFT: begin
            if (clk_fall) begin
              cnt_reg  <= EDGE_LOAD;
              edge_reg <= edge_reg + 1'b1;
              if (edge_reg == STOP_PREV) begin
                data_oe_reg <= 1'b0;
                state_reg   <= ACK;
              end else begin
                data_oe_reg <= ~shift_reg[0];
                shift_reg   <= shift_reg >> 1;
              end
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          ACK: begin
            if (clk_fall) begin
              result_reg <= ~data_level;
              cnt_reg    <= EDGE_LOAD;
              state_reg  <= WAIT_IDLE;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          WAIT_IDLE: begin
            if (progress) begin
              done_reg   <= 1'b1;
              ack_ok_reg <= result_reg;
              state_reg  <= DONE;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          DONE, FAIL: begin
            tx_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign tx_ready    = tx_ready_reg;
  assign busy        = busy_reg;
  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign done        = done_reg;
  assign ack_ok      = ack_ok_reg;

  logic unused_data_fall;
  assign unused_data_fall = data_fall;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// a scoreboard holds the expected frame and acknowledge result for each request.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       done, ack_ok, busy;

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  // Open-drain bus: either side may pull low.
  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  always #5 clock = ~clock;

  ps2_host_tx #(
    .CLK_FREQ_HZ           (1000000),
    .INHIBIT_US            (100),
    .FIRST_EDGE_TIMEOUT_US (15000),
    .EDGE_TIMEOUT_US       (2000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .done        (done),
    .ack_ok      (ack_ok),
    .busy        (busy)
  );

  typedef struct packed {
    logic [10:0] frame;
    logic        ack;
  } exp_t;

  exp_t exp_q[$];
  logic done_ack_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   cyc      = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;
  int   fe5_cyc  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (done) begin
      done_ack_q.push_back(ack_ok);
      done_cyc <= cyc;
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s: observed %0h expected %0h", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame as the device sees it: start, 8 data bits LSB first, odd parity, stop.
  function automatic logic [10:0] build_frame(input logic [7:0] d);
    int ones = 0;
    logic [10:0] f;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0]    = 1'b0;
    f[8:1]  = d;
    f[9]    = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10]   = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] d, input logic ack_exp);
    exp_t e;
    @(negedge clock);
    tx_data  = d;
    tx_valid = 1'b1;
    e.frame  = build_frame(d);
    e.ack    = ack_exp;
    exp_q.push_back(e);
    @(negedge clock);
    tx_valid = 1'b0;
    $display("txn send %02h", d);
  endtask

  task automatic dev_run(input int nedges, input logic do_ack, output logic [10:0] frame);
    int n = 0;
    frame = '1;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_i == 1'b0) && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) check("req_wait_bound", n, 0);
    repeat (5) @(negedge clock);
    for (int e = 1; e <= nedges; e++) begin
      frame[e-1] = ps2_data_i;
      if (e == 11) begin
        dev_data = ~do_ack;
        repeat (5) @(negedge clock);
      end
      dev_clk = 1'b0;
      if (e == 5) fe5_cyc = cyc;
      repeat (20) @(negedge clock);
      dev_clk = 1'b1;
      repeat (20) @(negedge clock);
    end
    dev_data = 1'b1;
  endtask

  task automatic finish_txn(input string tag, input int limit);
    int   n = 0;
    exp_t e;
    logic a;
    while (done_ack_q.size() == 0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    #1;
    check({tag, "_done_seen"}, done_ack_q.size(), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (done_ack_q.size() > 0) begin
      a = done_ack_q.pop_front();
      check({tag, "_ack_ok"}, a, e.ack);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] frame;
    int          n;
    int          t0;
    int          base;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // 0xED with ACK, including inhibit length and request-to-send
    send(8'hED, 1'b1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 1000) begin
      n++;
      @(negedge clock);
    end
    check("ED_inhibit_cycles", n, 100);
    check("ED_req_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
    dev_run(11, 1'b1, frame);
    check("ED_frame", frame, exp_q[0].frame);
    finish_txn("ED", 500);
    @(negedge clock);
    check("ED_tx_ready", tx_ready, 1);

    // Parity 0 and parity 1 bytes
    send(8'hF4, 1'b1);
    dev_run(11, 1'b1, frame);
    check("F4_frame", frame, exp_q[0].frame);
    finish_txn("F4", 500);

    send(8'h00, 1'b1);
    dev_run(11, 1'b1, frame);
    check("00_frame", frame, exp_q[0].frame);
    finish_txn("00", 500);

    // Device leaves data high on the ACK edge
    send(8'h55, 1'b0);
    dev_run(11, 1'b0, frame);
    check("55_frame", frame, exp_q[0].frame);
    finish_txn("noack", 500);
    @(negedge clock);
    check("noack_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // Device never clocks: timeout counted from the clock release
    send(8'hAA, 1'b0);
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 500) begin
      @(negedge clock);
      n++;
    end
    t0 = cyc;
    finish_txn("noclk", 16000);
    check("noclk_timeout_cycles", done_cyc - t0, 15000);
    @(negedge clock);
    check("noclk_data_oe", ps2_data_oe, 0);

    // Device stalls after fe 5: 2000-cycle edge timeout plus 3-cycle pin-to-fe latency
    send(8'h3C, 1'b0);
    dev_run(5, 1'b1, frame);
    finish_txn("stall", 3000);
    check("stall_timeout_cycles", done_cyc - fe5_cyc, 2003);

    // Reset during SHIFT after fe 4; bit3 of 0x00 keeps data pulled low
    send(8'h00, 1'b1);
    dev_run(4, 1'b1, frame);
    check("rst_mid_pre_data_oe", ps2_data_oe, 1);
    base = done_cnt;
    #1 reset = 1'b1;
    #1 check("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    void'(exp_q.pop_front());
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    check("rst_mid_no_done", done_cnt, base);
    check("rst_mid_tx_ready", tx_ready, 1);

    // 0xFF after reset, with a request pulsed while busy that must be dropped
    send(8'hFF, 1'b1);
    repeat (10) @(negedge clock);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    dev_run(11, 1'b1, frame);
    check("FF_frame", frame, exp_q[0].frame);
    finish_txn("FF", 500);
    n = 0;
    repeat (300) begin
      @(negedge clock);
      if (ps2_clk_oe || busy) n++;
    end
    check("FF_no_second_xfer", n, 0);
    check("FF_done_count", done_cnt, base + 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
